// File: rtl/univ_shift_reg.sv
// Parametrised universal register: synchronous reset, clock enable, parallel load,
// shift/rotate in both directions, and a saturating shift counter with a done flag.
module univ_shift_reg #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROL  = 3'd4,
    M_ROR  = 3'd5,
    M_CLR  = 3'd6,
    M_RSVD = 3'd7
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  mode_e            op;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             shifting;

  assign op = mode_e'(mode);

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = cnt;
    shifting = 1'b0;
    case (op)
      M_LOAD: begin
        q_nxt   = d;
        cnt_nxt = '0;
      end
      M_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin_l};
        shifting = 1'b1;
      end
      M_SHR: begin
        q_nxt    = {sin_r, q[WIDTH-1:1]};
        shifting = 1'b1;
      end
      M_ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        shifting = 1'b1;
      end
      M_ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        shifting = 1'b1;
      end
      M_CLR: begin
        q_nxt   = '0;
        cnt_nxt = '0;
      end
      default: ;
    endcase
    // counter saturates at WIDTH while q keeps moving
    if (shifting && (cnt != CNT_MAX))
      cnt_nxt = cnt + 1'b1;
  end

  // en is tested before the mode decode is used, so an unknown mode while disabled never reaches state
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RESET_VAL;
      cnt <= '0;
    end else if (en) begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign done   = (cnt == CNT_MAX);

endmodule
